// File: rtl/mips_pkg.sv
// Shared MIPS-core definitions: register-file geometry and the encoding of the
// register-dump reader FSM.
package mips_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  typedef enum logic [2:0] {
    RFD_IDLE = 3'd0,
    RFD_REQ  = 3'd1,
    RFD_READ = 3'd2,
    RFD_SEND = 3'd3,
    RFD_FIN  = 3'd4
  } rfd_state_e;

endpackage : mips_pkg

// File: rtl/rf_dump_reader.sv
// Register-file dump engine: stalls the pipeline, borrows read port 1 and streams
// registers 0..NREGS-1 out on a valid/ready interface, then pulses done.
module rf_dump_reader
  import mips_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          stall_req,
  input  logic          stall_ack,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output rfd_state_e    dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  // Output stream handshake: a word transfers on the rising edge where
  // out_valid && out_ready; once out_valid rises, out_data/out_index/out_last
  // hold steady and out_valid stays high until that transfer edge.

  rfd_state_e    r_state;
  rfd_state_e    w_next;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_oidx;
  logic          w_xfer;
  logic          w_capture;

  assign w_xfer    = (r_state == RFD_SEND) && out_ready;
  assign w_capture = (r_state == RFD_READ) && stall_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RFD_IDLE: if (start) w_next = RFD_REQ;
      RFD_REQ:  if (stall_ack) w_next = RFD_READ;
      RFD_READ: w_next = stall_ack ? RFD_SEND : RFD_REQ;
      RFD_SEND: if (w_xfer) w_next = (r_idx == LAST_IDX) ? RFD_FIN : RFD_READ;
      RFD_FIN:  w_next = RFD_IDLE;
      default:  w_next = RFD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RFD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The index only advances on a transfer, so a dropped ack re-reads the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_state == RFD_IDLE) begin
      r_idx <= '0;
    end else if (w_xfer && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_oidx <= '0;
    end else if (w_capture) begin
      r_data <= rd_data;
      r_oidx <= r_idx;
    end
  end

  assign stall_req = (r_state == RFD_REQ) || (r_state == RFD_READ) || (r_state == RFD_SEND);
  assign busy      = (r_state != RFD_IDLE);
  assign done      = (r_state == RFD_FIN);
  assign out_valid = (r_state == RFD_SEND);
  assign out_data  = r_data;
  assign out_index = r_oidx;
  assign out_last  = out_valid && (r_oidx == LAST_IDX);
  assign rd_addr   = r_idx;
  assign dbg_state = r_state;

endmodule : rf_dump_reader

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a register-file model feeds rd_data and a
// scoreboard queue holds the words each dump must emit, in order.
module tb_rf_dump_reader;
  import mips_pkg::*;

  localparam int W = 1 + RF_AW + RF_DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stall_req;
  logic              stall_ack;
  logic [RF_AW-1:0]  rd_addr;
  logic [RF_DW-1:0]  rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [RF_DW-1:0]  out_data;
  logic [RF_AW-1:0]  out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  rfd_state_e        dbg_state;

  logic [RF_DW-1:0]  rf [RF_NREGS];
  logic [W-1:0]      exp_q [$];
  int                n_assert = 0;
  int                n_fail   = 0;
  int                done_cnt = 0;
  int                ready_mode = 0;
  int                rcyc = 0;
  bit                hold_v = 1'b0;
  logic [RF_AW+RF_DW-1:0] hold_w;

  rf_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall_req (stall_req),
    .stall_ack (stall_ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / register-file model ----------------
  always #5 clk = ~clk;
  assign rd_data = rf[rd_addr];

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_rf(input bit basic);
    for (int i = 0; i < RF_NREGS; i++) begin
      if (basic) rf[i] = 32'(i * 3);
      else       rf[i] = (i == 0) ? 32'd0 : $urandom_range(32'hFFFF_FFFF, 0);
    end
    if (basic) rf[29] = 32'd1200;
  endtask

  task automatic push_dump();
    logic [RF_AW-1:0] idx;
    for (int i = 0; i < RF_NREGS; i++) begin
      idx = RF_AW'(i);
      exp_q.push_back({(i == RF_NREGS - 1), idx, rf[i]});
    end
  endtask

  // Runs one full dump; returns the negedge count (after the start edge) where done was seen.
  task automatic do_dump(input int ack_delay, input bit ack_drop, input int pulse_at,
                         input bit pulse_fin, output int n_done);
    int drop_cnt;
    bit dropped;
    dropped  = 1'b0;
    drop_cnt = 0;
    n_done   = 0;
    push_dump();
    stall_ack = (ack_delay == 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("req_stall", 64'(stall_req), 64'd1);
        chk("req_busy", 64'(busy), 64'd1);
        chk("req_no_valid", 64'(out_valid), 64'd0);
      end
      if (ack_delay > 0 && n <= ack_delay) begin
        chk("pre_ack_valid", 64'(out_valid), 64'd0);
        chk("pre_ack_state", 64'(dbg_state), 64'(RFD_REQ));
        if (n == ack_delay) stall_ack = 1'b1;
      end
      if (ack_drop) begin
        if (!dropped && dbg_state == RFD_READ && rd_addr == 5'd7) begin
          stall_ack = 1'b0;
          dropped   = 1'b1;
        end else if (dropped && drop_cnt < 3) begin
          drop_cnt++;
          if (drop_cnt == 1) begin
            chk("drop_to_req", 64'(dbg_state), 64'(RFD_REQ));
            chk("drop_no_valid", 64'(out_valid), 64'd0);
          end
          if (drop_cnt == 3) stall_ack = 1'b1;
        end
      end
      start = (n == pulse_at);
      if (done) begin
        n_done = n;
        if (pulse_fin) start = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(done), 64'd1);
    if (ack_drop) chk("ack_drop_seen", 64'(dropped), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      rcyc++;
      case (ready_mode)
        1:       out_ready = (rcyc % 3 == 0);
        2:       out_ready = (rd_addr != 5'd12);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_word", 64'({out_index, out_data}), 64'(hold_w));
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word_qdepth", 64'(exp_q.size()), 64'd1);
        else chk("word", 64'({out_last, out_index, out_data}), 64'(exp_q.pop_front()));
      end
      hold_v = out_valid && !out_ready;
      hold_w = {out_index, out_data};
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int d0;
    bit seen12;
    rst_n     = 1'b0;
    start     = 1'b0;
    stall_ack = 1'b0;
    out_ready = 1'b1;
    load_rf(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_req", 64'(stall_req), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic dump: READ at negedge 2, FIN 64 cycles later
    d0 = done_cnt;
    do_dump(0, 1'b0, 0, 1'b0, n);
    chk("done_latency", 64'(n), 64'd66);
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);

    // backpressure
    load_rf(1'b0);
    ready_mode = 1;
    do_dump(0, 1'b0, 0, 1'b0, n);
    ready_mode = 0;

    // delayed ack
    load_rf(1'b0);
    do_dump(5, 1'b0, 0, 1'b0, n);

    // ack drop during READ of index 7
    load_rf(1'b0);
    do_dump(0, 1'b1, 0, 1'b0, n);

    // reset while SEND holds index 12
    load_rf(1'b0);
    push_dump();
    ready_mode = 2;
    stall_ack  = 1'b1;
    seen12     = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid && out_index == 5'd12) begin
        seen12 = 1'b1;
        break;
      end
    end
    chk("hold12_seen", 64'(seen12), 64'd1);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall_req", 64'(stall_req), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_index", 64'(out_index), 64'd0);
    chk("arst_rd_addr", 64'(rd_addr), 64'd0);
    exp_q.delete();
    ready_mode = 0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    do_dump(0, 1'b0, 0, 1'b0, n);
    chk("restart_latency", 64'(n), 64'd66);

    // start pulses mid-dump and on the FIN cycle are ignored
    load_rf(1'b0);
    d0 = done_cnt;
    do_dump(0, 1'b0, 20, 1'b1, n);
    repeat (10) @(negedge clk);
    chk("ignored_start_busy", 64'(busy), 64'd0);
    chk("ignored_start_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("ignored_start_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_rf_dump_reader

// File: doc/rf_dump_reader.md
# rf_dump_reader

Debug read-out engine for the 32×32 MIPS register file. On a start pulse it requests a pipeline stall, takes ownership of one register-file read port, and walks registers 0..NREGS-1 in order. Each register value goes onto a valid/ready stream toward the trace/print logic, so the architectural state is dumped in hardware instead of by simulation file I/O. It sits beside the register file; the top level muxes the read1 address between the decode stage and this block using `busy`.

## Interface
- `NREGS`, 32: number of registers dumped; the counter wraps to idle after `NREGS-1`.
- `AW`, 5: register address width.
- `DW`, 32: register data width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle dump request; sampled only in IDLE.
- `stall_req`  out  1  asks the pipeline to freeze and drain writeback.
- `stall_ack`  in  1  pipeline is frozen, no RF write in flight, and the read port is free.
- `rd_addr`  out  AW  register-file read address (drives read1 via top mux).
- `rd_data`  in  DW  combinational register-file read data for `rd_addr`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DW  captured register value.
- `out_index`  out  AW  register number of `out_data`.
- `out_last`  out  1  high with the word for register `NREGS-1`.
- `busy`  out  1  high in every state except IDLE; selects this block on the read mux.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, REQ, READ, SEND, FIN.
- IDLE:
  - `start`=1 → REQ.
  - index counter cleared to 0.
- REQ:
  - `stall_req`=1.
  - `stall_ack`=1 → READ.
- READ:
  - `rd_addr`=index.
  - At the clock edge, `out_data`←`rd_data` and `out_index`←index.
  - If `stall_ack`=1 → SEND.
  - If `stall_ack` dropped → back to REQ, with no capture and no index change.
- SEND:
  - `out_valid`=1.
  - Word, index and last are held stable until `out_ready`.
  - On the valid∧ready edge: if index=`NREGS-1` → FIN, otherwise index+1 → READ.
- FIN:
  - `done`=1 for this single cycle.
  - `stall_req`=0.
  - → IDLE.
- `stall_req` is 1 in REQ, READ and SEND, and 0 in IDLE and FIN.
- `out_last` = (`out_index` == `NREGS-1`) while `out_valid`.
- Index arithmetic is unsigned AW-bit; no wrap occurs because FIN is taken at `NREGS-1`.
- Register 0 is dumped like any other register; its value is whatever the RF returns (0).
- `rd_addr` outside READ is held at the current index (don't-care for the RF; the mux uses `busy`).

## Timing
- Reset values:
  - state=IDLE, index=0.
  - `stall_req`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0.
  - `busy`=0, `done`=0, `rd_addr`=0.
- Cycle sequence:
  - `start` high at edge E0 → REQ; `stall_req` and `busy` are high after E0.
  - `stall_ack` high at edge E1 → READ.
  - Capture at E2 → `out_valid` high after E2.
- Throughput: 2 cycles per word when `out_ready` is held high. A full dump of 32 words is 64 cycles from the first READ to FIN, plus the REQ wait.
- Handshake:
  - Transfer occurs on the edge where valid∧ready.
  - `out_valid` never drops without a transfer.
  - `out_data` never changes while valid∧¬ready.
- `stall_ack` is ignored in SEND, because the word is already captured.
- `start` while `busy` is ignored; there is no queueing.
- `rst_n` low mid-dump: all outputs return to reset values immediately (asynchronously), and the partial dump is abandoned with no `done`.
- Simultaneous `start` and FIN: `start` is ignored, since FIN is not IDLE.

## Structure
- Shared package `mips_pkg`:
  - state encoding enum for this FSM.
  - constants `RF_NREGS`=32, `RF_AW`=5, `RF_DW`=32.
- Single module, no sub-modules. The read-port mux (`busy ? rd_addr : decode_rs`) lives at the top level, not in this block.

## Test plan
- Basic dump:
  - Stimulus: RF preloaded rf[i]=i*3, rf[29]=1200; `start`; `stall_ack` tied high; `out_ready` high.
  - Required: 32 words, indices 0..31 in order, values i*3 except word 29 = 1200; `out_last` only on index 31; `done` 64 cycles after the first READ.
- Backpressure:
  - Stimulus: `out_ready` toggling 1-of-3 cycles.
  - Required: identical word sequence; `out_data` and `out_index` stable while valid∧¬ready; no drops or duplicates.
- Delayed ack:
  - Stimulus: `stall_ack` asserted 5 cycles after `stall_req`.
  - Required: `rd_addr` not used and `out_valid` stays 0 until the ack; first word is index 0.
- Ack drop:
  - Stimulus: deassert `stall_ack` during the READ of index 7 for 3 cycles.
  - Required: FSM returns to REQ; index 7 is emitted exactly once after re-ack.
- Reset mid-dump:
  - Stimulus: `rst_n` low while SEND holds index 12.
  - Required: `out_valid`, `busy`, `stall_req` go 0 immediately; no `done`.
  - Follow-up: a fresh `start` restarts at index 0.
- Ignored start:
  - Stimulus: `start` pulsed during the dump and on the FIN cycle.
  - Required: exactly one 32-word dump and one `done` pulse.
